sm_imem_loadable: RTL

Parametrised instruction memory for each node of the multicore fabric. It has two ports:
- a combinational word-addressed fetch port for the single-cycle core;
- a streaming loader port that writes program words at run time.

The loader lets the network or host boot each core without rebuilding the bitstream. While a load is in progress, the block holds its core in reset through cpu_hold.

---
 rtl/sm_imem_loadable.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sm_imem_loadable.sv
// rtl/sm_imem_loadable.sv - loadable per-node instruction memory with combinational fetch port
// Optional: SM_IMEM_CHECKSUM_EN enables the ld_csum running sum of written words.
module sm_imem_loadable #(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6,
  parameter int          NODE_ID   = 0,
  parameter logic [31:0] FILL_WORD = 32'h00000063,
  parameter logic [31:0] OOR_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  output logic [31:0]       rd,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count,
  output logic [31:0]       ld_csum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  typedef logic [31:0] mem_t [DEPTH];

  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0]     BOOT_WORD = (NODE_ID == 0) ? 32'h00500293 : 32'h00000063;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = FILL_WORD;
    m[0] = BOOT_WORD;
    return m;
  endfunction

  // Power-up image only; reset deliberately leaves the contents alone.
  mem_t mem_q = init_mem();

  state_t          state_q, state_d;
  // One bit wider than ld_base so the pointer can park at DEPTH instead of wrapping.
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;
  logic            in_range;
  logic            we;

  assign in_range = (ptr_q < DEPTH_W);
  assign we       = (state_q == LOAD) && ld_valid && in_range;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = {1'b0, ld_base};
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (in_range) ptr_d = ptr_q + 1'b1;
          else          err_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (ld_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q[ADDR_W-1:0]] <= ld_data;
  end

  // Fetch compares the full 32-bit address so aliases above DEPTH read as a nop.
  assign rd = (a < 32'(DEPTH)) ? mem_q[a[ADDR_W-1:0]] : OOR_WORD;

  assign ld_ready = (state_q == LOAD);
  assign cpu_hold = (state_q != IDLE);
  assign ld_done  = (state_q == DONE);
  assign ld_err   = err_q;
  assign ld_count = count_q;

`ifdef SM_IMEM_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && ld_start) csum_d = '0;
    else if (we)                     csum_d = csum_q + ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign ld_csum = csum_q;
`else
  assign ld_csum = '0;
`endif

endmodule
